// File: rtl/uncrop_pad_if.sv
// Pixel stream pair for uncrop_pad: cropped input stream in, padded output stream out.
// slave is the block's view; master is the driver/sink side.
interface uncrop_pad_if #(
    parameter int PIXEL_BIT_WIDTH = 12
);
    logic [PIXEL_BIT_WIDTH-1:0] pixel_in;
    logic                       in_valid;
    logic                       in_ready;
    logic [PIXEL_BIT_WIDTH-1:0] pixel_out;
    logic                       out_valid;
    logic                       out_ready;
    logic                       out_last;

    modport slave (
        input  pixel_in, in_valid, out_ready,
        output in_ready, pixel_out, out_valid, out_last
    );

    modport master (
        output pixel_in, in_valid, out_ready,
        input  in_ready, pixel_out, out_valid, out_last
    );
endinterface

// File: rtl/uncrop_pad.sv
// Embeds an IN_ROWS x IN_COLS raster into an OUT_ROWS x OUT_COLS frame at (Y_1, X_1), padding elsewhere.
// One register stage (input to output next cycle); input only stalls output at window positions.
module uncrop_pad #(
    parameter int PIXEL_BIT_WIDTH = 12,
    parameter int IN_ROWS         = 20,
    parameter int IN_COLS         = 20,
    parameter int OUT_ROWS        = 40,
    parameter int OUT_COLS        = 40,
    parameter int Y_1             = 10,
    parameter int X_1             = 10,
    parameter logic [PIXEL_BIT_WIDTH-1:0] PAD_VALUE = '0
) (
    input  logic         clk,
    input  logic         reset,
    uncrop_pad_if.slave  io
);
    // One spare bit so the exclusive window end (Y_1+IN_ROWS <= OUT_ROWS) is representable.
    localparam int RW = $clog2(OUT_ROWS + 1);
    localparam int CW = $clog2(OUT_COLS + 1);

    localparam logic [RW-1:0] ROW_LO  = RW'(Y_1);
    localparam logic [RW-1:0] ROW_N   = RW'(IN_ROWS);
    localparam logic [RW-1:0] ROW_MAX = RW'(OUT_ROWS - 1);
    localparam logic [CW-1:0] COL_LO  = CW'(X_1);
    localparam logic [CW-1:0] COL_N   = CW'(IN_COLS);
    localparam logic [CW-1:0] COL_MAX = CW'(OUT_COLS - 1);

    generate
        if (Y_1 + IN_ROWS > OUT_ROWS || X_1 + IN_COLS > OUT_COLS) begin : g_bad_geometry
            $error("uncrop_pad: input window does not fit inside the output frame");
        end
    endgenerate

    logic [RW-1:0] r;
    logic [CW-1:0] c;
    logic          pass;
    logic          can_adv;
    logic          load;
    logic          at_end;

    // Offset subtraction wraps below the window start to a value >= the window size.
    assign pass    = ((r - ROW_LO) < ROW_N) && ((c - COL_LO) < COL_N);
    assign can_adv = !io.out_valid || io.out_ready;
    assign load    = can_adv && (!pass || io.in_valid);
    assign at_end  = (r == ROW_MAX) && (c == COL_MAX);

    assign io.in_ready = pass && can_adv && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            r            <= '0;
            c            <= '0;
            io.pixel_out <= '0;
            io.out_valid <= 1'b0;
            io.out_last  <= 1'b0;
        end else if (load) begin
            io.pixel_out <= pass ? io.pixel_in : PAD_VALUE;
            io.out_valid <= 1'b1;
            io.out_last  <= at_end;
            if (c == COL_MAX) begin
                c <= '0;
                r <= (r == ROW_MAX) ? '0 : r + 1'b1;
            end else begin
                c <= c + 1'b1;
            end
        end else if (io.out_ready) begin
            io.out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_uncrop_pad.sv
// Scoreboard bench for uncrop_pad in a 2x2 -> 4x4 configuration with the window at (1,1).
module tb_uncrop_pad;
    typedef struct {
        logic [11:0] pix;
        logic        last;
    } exp_t;

    logic clk;
    logic reset;

    uncrop_pad_if #(.PIXEL_BIT_WIDTH(12)) io ();

    uncrop_pad #(
        .PIXEL_BIT_WIDTH(12),
        .IN_ROWS(2),
        .IN_COLS(2),
        .OUT_ROWS(4),
        .OUT_COLS(4),
        .Y_1(1),
        .X_1(1),
        .PAD_VALUE(12'd0)
    ) dut (
        .clk(clk),
        .reset(reset),
        .io(io)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t        exp_q[$];
    logic [11:0] src_q[$];
    int checks   = 0;
    int failures = 0;
    int in_mode  = 0;
    int out_mode = 0;
    int cyc      = 0;
    int out_cnt, last_cnt, consumed, rdy_cnt, first_cyc, last_cyc;

    // Output layout of one 4x4 frame: 0 = pad, k = k-th input pixel of the frame.
    int sel[16] = '{0, 0, 0, 0, 0, 1, 2, 0, 0, 3, 4, 0, 0, 0, 0, 0};

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, act, req);
        end
    endtask

    // Monitor: every accepted output is popped from the scoreboard and compared.
    always @(negedge clk) begin
        if (!reset && io.out_valid && io.out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_output got pix=%0d last=%0b expected none", io.pixel_out, io.out_last);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (io.pixel_out !== e.pix || io.out_last !== e.last) begin
                    failures++;
                    $display("FAIL output got pix=%0d last=%0b expected pix=%0d last=%0b",
                             io.pixel_out, io.out_last, e.pix, e.last);
                end
            end
        end
    end

    task automatic push_frame(input int a, input int b, input int c, input int d);
        int px[4];
        exp_t e;
        px = '{a, b, c, d};
        for (int i = 0; i < 16; i++) begin
            e.pix  = (sel[i] == 0) ? 12'd0 : 12'(px[sel[i]-1]);
            e.last = (i == 15);
            exp_q.push_back(e);
        end
    endtask

    task automatic drive();
        io.pixel_in  = (src_q.size() > 0) ? src_q[0] : 12'd0;
        io.in_valid  = (src_q.size() > 0) && (in_mode == 1 || (in_mode == 2 && $urandom_range(0, 1) == 1));
        io.out_ready = (exp_q.size() > 0) && (out_mode == 1 || (out_mode == 2 && $urandom_range(0, 1) == 1));
    endtask

    task automatic step();
        logic fire_in;
        logic fire_out;
        @(negedge clk);
        if (io.in_ready) rdy_cnt++;
        fire_in  = io.in_valid && io.in_ready;
        fire_out = io.out_valid && io.out_ready;
        if (fire_out) begin
            if (out_cnt == 0) first_cyc = cyc;
            last_cyc = cyc;
            out_cnt++;
            if (io.out_last) last_cnt++;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (fire_in) begin
            void'(src_q.pop_front());
            consumed++;
        end
        drive();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        exp_q.delete();
        src_q.delete();
        io.in_valid  = 1'b1;
        io.out_ready = 1'b1;
        @(negedge clk);
        chk("rst_in_ready_comb", int'(io.in_ready), 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_out_valid", int'(io.out_valid), 0);
        chk("rst_out_last", int'(io.out_last), 0);
        chk("rst_pixel_out", int'(io.pixel_out), 0);
        chk("rst_in_ready", int'(io.in_ready), 0);
        @(posedge clk); #1;
        reset        = 1'b0;
        io.in_valid  = 1'b0;
        io.out_ready = 1'b0;
        io.pixel_in  = 12'd0;
        out_cnt = 0; last_cnt = 0; consumed = 0; rdy_cnt = 0; first_cyc = 0; last_cyc = 0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            step();
            n++;
        end
        chk(name, exp_q.size(), 0);
    endtask

    initial begin
        int n;
        reset        = 1'b1;
        io.pixel_in  = 12'd0;
        io.in_valid  = 1'b0;
        io.out_ready = 1'b0;

        // Single frame at full throughput.
        do_reset();
        for (int i = 1; i <= 4; i++) src_q.push_back(12'(i));
        push_frame(1, 2, 3, 4);
        in_mode = 1; out_mode = 1;
        drive();
        wait_done("f1_drain", 60);
        chk("f1_outputs", out_cnt, 16);
        chk("f1_last_count", last_cnt, 1);
        chk("f1_consumed", consumed, 4);
        chk("f1_in_ready_cycles", rdy_cnt, 4);
        chk("f1_no_bubbles", last_cyc - first_cyc, 15);

        // No input: five pads, then the window start stalls.
        do_reset();
        in_mode = 0; out_mode = 1;
        for (int i = 0; i < 5; i++) exp_q.push_back('{pix: 12'd0, last: 1'b0});
        drive();
        wait_done("starve_drain", 30);
        rdy_cnt = 0;
        repeat (4) step();
        chk("starve_out_valid", int'(io.out_valid), 0);
        chk("starve_in_ready_held", rdy_cnt, 4);
        chk("starve_outputs", out_cnt, 5);

        // Output backpressure while pixel 1 is presented.
        do_reset();
        for (int i = 1; i <= 4; i++) src_q.push_back(12'(i));
        push_frame(1, 2, 3, 4);
        in_mode = 1; out_mode = 1;
        drive();
        repeat (6) step();
        out_mode = 0;
        drive();
        chk("stall_consumed_before", consumed, 1);
        rdy_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_pixel_out", int'(io.pixel_out), 1);
            chk("stall_out_valid", int'(io.out_valid), 1);
            chk("stall_out_last", int'(io.out_last), 0);
        end
        chk("stall_in_ready", rdy_cnt, 0);
        chk("stall_consumed_after", consumed, 1);
        out_mode = 1;
        drive();
        wait_done("stall_drain", 60);
        chk("stall_total_consumed", consumed, 4);

        // Two back-to-back frames.
        do_reset();
        for (int i = 1; i <= 8; i++) src_q.push_back(12'(i));
        push_frame(1, 2, 3, 4);
        push_frame(5, 6, 7, 8);
        in_mode = 1; out_mode = 1;
        drive();
        wait_done("b2b_drain", 100);
        chk("b2b_outputs", out_cnt, 32);
        chk("b2b_no_gap", last_cyc - first_cyc, 31);
        chk("b2b_last_count", last_cnt, 2);
        chk("b2b_consumed", consumed, 8);

        // Random handshakes over three frames.
        do_reset();
        for (int i = 1; i <= 12; i++) src_q.push_back(12'(100 + i));
        push_frame(101, 102, 103, 104);
        push_frame(105, 106, 107, 108);
        push_frame(109, 110, 111, 112);
        in_mode = 2; out_mode = 2;
        drive();
        wait_done("rand_drain", 800);
        chk("rand_outputs", out_cnt, 48);
        chk("rand_last_count", last_cnt, 3);
        chk("rand_consumed", consumed, 12);

        // Reset in the middle of a frame, then a fresh frame.
        do_reset();
        for (int i = 1; i <= 4; i++) src_q.push_back(12'(40 + i));
        push_frame(41, 42, 43, 44);
        in_mode = 1; out_mode = 1;
        drive();
        n = 0;
        while (out_cnt < 7 && n < 50) begin
            step();
            n++;
        end
        chk("mid_progress", out_cnt, 7);
        do_reset();
        for (int i = 1; i <= 4; i++) src_q.push_back(12'(i));
        push_frame(1, 2, 3, 4);
        in_mode = 1; out_mode = 1;
        drive();
        wait_done("mid_drain", 60);
        chk("mid_outputs", out_cnt, 16);
        chk("mid_consumed", consumed, 4);
        chk("mid_last_count", last_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
